aes_key_schedule: RTL and testbench

- Iterative AES key-expansion engine for AES-128, AES-192 and AES-256, with the key size selected per run.
- Produces one 32-bit schedule word per cycle using a sliding window of the last Nk words.
- Packs every 4 words into a 128-bit round key and streams round keys 0..Nr out over a valid/ready interface.
- Feeds the round pipeline; supersedes the fixed AES-128 single-round expander.

---
 rtl/aes_key_schedule.sv | 184 ++++++++++++++++++
 tb/tb_aes_key_schedule.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key expansion: one schedule word per cycle from a sliding window
// of the last Nk words, packed into 128-bit round keys on a valid/ready stream.
module aes_key_schedule #(
  parameter int unsigned MAX_KEY_BITS    = 256,
  parameter int unsigned SUBBYTE_LATENCY = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   key_size,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         done,
  output logic         cfg_err
);

  typedef enum logic [2:0] {StIdle, StLoad, StExpand, StWait, StFlush} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as multiplicative inverse (a^254) followed by the affine transform
  function automatic logic [7:0] s_box(input logic [7:0] a);
    logic [7:0] a3, a15, a63, a127, inv;
    a3   = gf_mul(gf_mul(a, a), a);
    a15  = gf_mul(gf_mul(gf_mul(a3, a3), gf_mul(a3, a3)), a3);
    a63  = gf_mul(gf_mul(gf_mul(a15, a15), gf_mul(a15, a15)), a3);
    a127 = gf_mul(gf_mul(a63, a63), a);
    inv  = gf_mul(a127, a127);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {s_box(w[31:24]), s_box(w[23:16]), s_box(w[15:8]), s_box(w[7:0])};
  endfunction

  state_e         state_q;
  logic [255:0]   key_q;
  logic [31:0]    win_q [8];
  logic [95:0]    acc_q;
  logic [5:0]     word_q;
  logic [2:0]     mod_q;
  logic [7:0]     rcon_q;
  logic [3:0]     nk_q;
  logic [3:0]     nr_q;
  logic [5:0]     total_q;

  int unsigned    req_bits;
  logic           legal;
  logic [2:0]     old_idx;
  logic           rot, need_sub, stall, wait_needed, write_en;
  logic [31:0]    w_prev, sub_in, sub_comb, sub_val, temp, new_word;

  always_comb begin
    req_bits = 256;
    case (key_size)
      2'b00:   req_bits = 128;
      2'b01:   req_bits = 192;
      default: req_bits = 256;
    endcase
  end
  assign legal = (key_size != 2'b11) && (req_bits <= MAX_KEY_BITS);

  // win_q[0] is w[i-1], win_q[Nk-1] is w[i-Nk]
  assign old_idx     = nk_q[2:0] - 3'd1;
  assign w_prev      = win_q[0];
  assign rot         = (mod_q == 3'd0);
  assign need_sub    = rot || ((nk_q == 4'd8) && (mod_q == 3'd4));
  assign sub_in      = rot ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign sub_comb    = sub_word(sub_in);

  if (SUBBYTE_LATENCY == 1) begin : g_sub_reg
    logic [31:0] sub_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) sub_q <= '0;
      else       sub_q <= sub_comb;
    end
    assign sub_val = sub_q;
  end else begin : g_sub_comb
    assign sub_val = sub_comb;
  end

  assign temp        = need_sub ? (sub_val ^ {(rot ? rcon_q : 8'h00), 24'h0}) : w_prev;
  assign new_word    = (state_q == StLoad) ? key_q[255:224] : (win_q[old_idx] ^ temp);
  assign stall       = rk_valid && !rk_ready;
  assign wait_needed = (SUBBYTE_LATENCY == 1) && need_sub && (state_q == StExpand);
  assign write_en    = !stall && ((state_q == StLoad) || (state_q == StWait) ||
                                  ((state_q == StExpand) && !wait_needed));
  assign done        = rk_valid && rk_ready && (state_q == StFlush) && (rk_index == nr_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      key_q    <= '0;
      for (int k = 0; k < 8; k++) win_q[k] <= '0;
      acc_q    <= '0;
      word_q   <= '0;
      mod_q    <= '0;
      rcon_q   <= '0;
      nk_q     <= '0;
      nr_q     <= '0;
      total_q  <= '0;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= '0;
      rk_index <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start && legal) begin
            state_q <= StLoad;
            busy    <= 1'b1;
            key_q   <= key_in;
            word_q  <= '0;
            mod_q   <= '0;
            rcon_q  <= 8'h01;
            case (key_size)
              2'b00:   begin nk_q <= 4'd4; nr_q <= 4'd10; total_q <= 6'd44; end
              2'b01:   begin nk_q <= 4'd6; nr_q <= 4'd12; total_q <= 6'd52; end
              default: begin nk_q <= 4'd8; nr_q <= 4'd14; total_q <= 6'd60; end
            endcase
          end else if (start) begin
            cfg_err <= 1'b1;
          end
        end
        StExpand: if (!stall && wait_needed) state_q <= StWait;
        StFlush: begin
          if (done) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end
        default: ;
      endcase

      if (write_en) begin
        for (int k = 7; k > 0; k--) win_q[k] <= win_q[k-1];
        win_q[0] <= new_word;
        word_q   <= word_q + 6'd1;
        mod_q    <= (mod_q == old_idx) ? 3'd0 : mod_q + 3'd1;
        if (state_q == StLoad) key_q <= {key_q[223:0], 32'h0};
        if (state_q != StLoad && rot) begin
          rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        case (word_q[1:0])
          2'd0: acc_q[95:64] <= new_word;
          2'd1: acc_q[63:32] <= new_word;
          2'd2: acc_q[31:0]  <= new_word;
          default: begin
            rk_data  <= {acc_q, new_word};
            rk_index <= word_q[5:2];
            rk_valid <= 1'b1;
          end
        endcase
        if (word_q == total_q - 6'd1) begin
          state_q <= StFlush;
        end else if (state_q == StLoad && word_q == {3'b000, old_idx}) begin
          state_q <= StExpand;
        end else if (state_q == StWait) begin
          state_q <= StExpand;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_schedule.sv
// Bench for aes_key_schedule: a table-driven reference expansion fills a scoreboard of round
// keys that are popped and compared on every handshake, plus FIPS-197 spot values and timing.
module tb_aes_key_schedule;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] data;
  } rk_t;

  logic         clk, reset, rk_ready;
  logic         start_a, start_l, start_m;
  logic [1:0]   key_size;
  logic [255:0] key_in;

  logic         busy_a, rk_valid_a, done_a, cfg_err_a;
  logic         busy_l, rk_valid_l, done_l, cfg_err_l;
  logic         busy_m, rk_valid_m, done_m, cfg_err_m;
  logic [127:0] rk_data_a, rk_data_l, rk_data_m;
  logic [3:0]   rk_index_a, rk_index_l, rk_index_m;

  aes_key_schedule dut (
    .clk(clk), .reset(reset), .start(start_a), .key_size(key_size), .key_in(key_in),
    .busy(busy_a), .rk_valid(rk_valid_a), .rk_ready(rk_ready), .rk_data(rk_data_a),
    .rk_index(rk_index_a), .done(done_a), .cfg_err(cfg_err_a)
  );

  aes_key_schedule #(.SUBBYTE_LATENCY(1)) dut_lat (
    .clk(clk), .reset(reset), .start(start_l), .key_size(key_size), .key_in(key_in),
    .busy(busy_l), .rk_valid(rk_valid_l), .rk_ready(rk_ready), .rk_data(rk_data_l),
    .rk_index(rk_index_l), .done(done_l), .cfg_err(cfg_err_l)
  );

  aes_key_schedule #(.MAX_KEY_BITS(128)) dut_128 (
    .clk(clk), .reset(reset), .start(start_m), .key_size(key_size), .key_in(key_in),
    .busy(busy_m), .rk_valid(rk_valid_m), .rk_ready(rk_ready), .rk_data(rk_data_m),
    .rk_index(rk_index_m), .done(done_m), .cfg_err(cfg_err_m)
  );

  int           errors, checks, sel, rk_seen, done_cnt, cycles;
  logic [3:0]   last_idx;
  rk_t          exp_q[$];
  logic [127:0] got_rk [16];
  logic [0:255][7:0] sbox_tab;

  logic         m_busy, m_valid, m_done, m_cfg;
  logic [127:0] m_data;
  logic [3:0]   m_index;

  always_comb begin
    m_busy = busy_a; m_valid = rk_valid_a; m_done = done_a; m_cfg = cfg_err_a;
    m_data = rk_data_a; m_index = rk_index_a;
    if (sel == 1) begin
      m_busy = busy_l; m_valid = rk_valid_l; m_done = done_l; m_cfg = cfg_err_l;
      m_data = rk_data_l; m_index = rk_index_l;
    end else if (sel == 2) begin
      m_busy = busy_m; m_valid = rk_valid_m; m_done = done_m; m_cfg = cfg_err_m;
      m_data = rk_data_m; m_index = rk_index_m;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int k);
    case (k)
      0: return 8'h01; 1: return 8'h02; 2: return 8'h04; 3: return 8'h08; 4: return 8'h10;
      5: return 8'h20; 6: return 8'h40; 7: return 8'h80; 8: return 8'h1b; default: return 8'h36;
    endcase
  endfunction

  task automatic push_model(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    int nr, total;
    rk_t e;
    nr = nk + 6;
    total = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / nk - 1), 24'h0};
      else if (nk == 8 && i % 8 == 4) t = subw(t);
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.idx  = 4'(r);
      e.data = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      exp_q.push_back(e);
    end
    last_idx = 4'(nr);
  endtask

  // Scoreboard consumer and stall-stability monitor
  initial begin
    logic         stall_prev;
    logic [127:0] held_data;
    logic [3:0]   held_idx;
    rk_t          e;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_prev = 1'b0;
        continue;
      end
      if (stall_prev) begin
        chk("stall_data_hold", m_data, held_data);
        chk("stall_index_hold", 128'(m_index), 128'(held_idx));
      end
      if (m_valid && rk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_rk: got index %0d expected no round key", m_index);
        end else begin
          e = exp_q.pop_front();
          chk("rk_index", 128'(m_index), 128'(e.idx));
          chk("rk_data", m_data, e.data);
          chk("done_flag", 128'(m_done), 128'(e.idx == last_idx));
          got_rk[m_index] = m_data;
          rk_seen++;
        end
      end
      if (m_done) done_cnt++;
      stall_prev = m_valid && !rk_ready;
      held_data  = m_data;
      held_idx   = m_index;
    end
  end

  task automatic start_case(input int which, input logic [1:0] ks, input logic [255:0] key,
                            input int nk);
    sel = which;
    rk_seen = 0;
    done_cnt = 0;
    exp_q.delete();
    push_model(key, nk);
    @(posedge clk); #1;
    key_size = ks;
    key_in = key;
    start_a = (which == 0);
    start_l = (which == 1);
    @(posedge clk); #1;
    start_a = 1'b0;
    start_l = 1'b0;
    key_in = ~key;
    key_size = 2'b11;
    chk("busy_after_start", 128'(m_busy), 128'd1);
  endtask

  task automatic wait_done(input string tag, input int max, input logic rnd, input logic poke,
                           output int cyc);
    logic seen;
    seen = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (m_done) begin
        seen = 1'b1;
        break;
      end
      if (cyc >= max) break;
      @(posedge clk); #1;
      rk_ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
      start_a = poke && (cyc == 8);
      key_size = 2'b00;
      cyc++;
    end
    start_a = 1'b0;
    rk_ready = 1'b1;
    chk({tag, "_done_seen"}, 128'(seen), 128'd1);
  endtask

  task automatic end_case(input string tag, input int nr);
    @(posedge clk); #1;
    chk({tag, "_busy_low"}, 128'(m_busy), 128'd0);
    chk({tag, "_valid_low"}, 128'(m_valid), 128'd0);
    chk({tag, "_rk_count"}, 128'(rk_seen), 128'(nr + 1));
    chk({tag, "_done_count"}, 128'(done_cnt), 128'd1);
    chk({tag, "_queue_empty"}, 128'(exp_q.size()), 128'd0);
  endtask

  task automatic cfg_case(input string tag, input int which, input logic [1:0] ks);
    sel = which;
    @(posedge clk); #1;
    key_size = ks;
    start_a = (which == 0);
    start_m = (which == 2);
    @(posedge clk); #1;
    start_a = 1'b0;
    start_m = 1'b0;
    chk({tag, "_cfg_err_high"}, 128'(m_cfg), 128'd1);
    chk({tag, "_busy_low"}, 128'(m_busy), 128'd0);
    @(posedge clk); #1;
    chk({tag, "_cfg_err_pulse"}, 128'(m_cfg), 128'd0);
    chk({tag, "_still_idle"}, 128'(m_busy), 128'd0);
  endtask

  localparam logic [255:0] Key128 = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                                     128'hdeadbeef0123456789abcdeffedcba98};
  localparam logic [255:0] Key192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'hcafef00d55aa33cc};
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    logic found;
    errors = 0; checks = 0; sel = 0; rk_seen = 0; done_cnt = 0; last_idx = '0;
    sbox_tab = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    reset = 1'b1; rk_ready = 1'b1; start_a = 1'b0; start_l = 1'b0; start_m = 1'b0;
    key_size = 2'b00; key_in = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(busy_a), 128'd0);
    chk("reset_rk_valid", 128'(rk_valid_a), 128'd0);
    chk("reset_rk_data", rk_data_a, 128'd0);
    chk("reset_rk_index", 128'(rk_index_a), 128'd0);
    chk("reset_done", 128'(done_a), 128'd0);
    chk("reset_cfg_err", 128'(cfg_err_a), 128'd0);
    reset = 1'b0;

    start_case(0, 2'b00, Key128, 4);
    wait_done("aes128", 200, 1'b0, 1'b0, cycles);
    chk("aes128_latency", 128'(cycles), 128'd44);
    end_case("aes128", 10);
    chk("aes128_rk0", got_rk[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("aes128_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("aes128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    start_case(0, 2'b01, Key192, 6);
    wait_done("aes192", 200, 1'b0, 1'b1, cycles);
    end_case("aes192", 12);
    chk("aes192_w6", 128'(got_rk[1][63:32]), 128'h0000_0000_0000_0000_0000_0000_fe0c_91f7);
    chk("aes192_rk12", got_rk[12], 128'he98ba06f448c773c8ecc720401002202);

    start_case(0, 2'b10, Key256, 8);
    wait_done("aes256", 200, 1'b0, 1'b0, cycles);
    end_case("aes256", 14);
    chk("aes256_rk1", got_rk[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("aes256_w8", 128'(got_rk[2][127:96]), 128'h0000_0000_0000_0000_0000_0000_9ba3_5411);
    chk("aes256_rk14", got_rk[14], 128'hfe4890d1e6188d0b046df344706c631e);

    start_case(0, 2'b10, Key256, 8);
    wait_done("aes256_bp", 600, 1'b1, 1'b0, cycles);
    end_case("aes256_bp", 14);

    cfg_case("illegal_size", 0, 2'b11);
    cfg_case("unsupported_256", 2, 2'b10);

    start_case(0, 2'b00, Key128, 4);
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (m_valid && m_index == 4'd5) found = 1'b1;
    end
    chk("reset_round5_reached", 128'(found), 128'd1);
    reset = 1'b1;
    #1;
    chk("midrun_reset_busy", 128'(busy_a), 128'd0);
    chk("midrun_reset_valid", 128'(rk_valid_a), 128'd0);
    chk("midrun_reset_data", rk_data_a, 128'd0);
    chk("midrun_reset_index", 128'(rk_index_a), 128'd0);
    chk("midrun_reset_done", 128'(done_a), 128'd0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    start_case(0, 2'b00, Key128, 4);
    wait_done("restart128", 200, 1'b0, 1'b0, cycles);
    end_case("restart128", 10);

    start_case(1, 2'b00, Key128, 4);
    wait_done("lat128", 200, 1'b0, 1'b0, cycles);
    chk("lat128_latency", 128'(cycles), 128'd54);
    end_case("lat128", 10);
    chk("lat128_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
